// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
// Holds a CPU-written sprite attribute table. During horizontal blanking it
// reprograms a small pool of sprite detector slots with the sprites that
// cross the next scanline. The writes go out over the shared register bus.
// Optional feature macro: SPRITE_SCHED_OVERFLOW_EN. It enables the sticky
// overflow flag and the control register that clears it.
//
// Handshake: there is no back-pressure. Each sched_write_o pulse lasts one
// cycle and is one complete register write, with sched_index_o and
// sched_value_o valid in that same cycle. The detectors must accept it.
//
// State is visible to bound checkers as state_q: 0 idle, 1 clear, 2 scan,
// 3 load.
module sprite_line_scheduler #(
  parameter int          NUM_SPRITES   = 16,
  parameter int          NUM_SLOTS     = 4,
  parameter logic [11:0] SLOT_BASE     = 12'h000,
  parameter logic [11:0] TABLE_BASE    = 12'h100,
  parameter int          H_BLANK_START = 640,
  parameter int          V_TOTAL       = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  raster_x,
  input  logic [9:0]  raster_y,
  input  logic        register_write_i,
  input  logic [11:0] register_index_i,
  input  logic [15:0] register_write_value_i,
  output logic        sched_write_o,
  output logic [11:0] sched_index_o,
  output logic [15:0] sched_value_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int SW = $clog2(NUM_SLOTS + 1);
  localparam int CW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  // Attribute table
  logic [9:0] tbl_x     [NUM_SPRITES];
  logic [9:0] tbl_y     [NUM_SPRITES];
  logic [3:0] tbl_shape [NUM_SPRITES];
  logic       tbl_en    [NUM_SPRITES];

  // Scheduler state
  logic [1:0]    state_q;
  logic [9:0]    target_q;
  logic [IW-1:0] n_q;
  logic [SW-1:0] slot_q;
  logic [CW-1:0] clr_q;
  logic [1:0]    fld_q;

  // CPU table write decode: entry n, field k lives at TABLE_BASE + 4*n + k
  logic [11:0]   tbl_off;
  logic          tbl_wr;
  logic [IW-1:0] wr_n;

  assign tbl_off = register_index_i - TABLE_BASE;
  assign tbl_wr  = register_write_i && (register_index_i >= TABLE_BASE) &&
                   (tbl_off < 12'(4 * NUM_SPRITES));
  assign wr_n    = tbl_off[IW+1:2];

  // Scan helpers: the 10-bit modular distance makes y near 1023 wrap onto low lines
  logic [9:0] y_diff;
  logic       cur_hit;
  logic       last_n;
  logic       slots_full;
  logic       trigger;
  logic [9:0] next_line;

  assign y_diff     = target_q - tbl_y[n_q];
  assign cur_hit    = tbl_en[n_q] && (y_diff[9:4] == 6'd0);
  assign last_n     = (n_q == IW'(NUM_SPRITES - 1));
  assign slots_full = (slot_q == SW'(NUM_SLOTS));
  assign trigger    = (raster_x == 10'(H_BLANK_START));
  assign next_line  = (raster_y == 10'(V_TOTAL - 1)) ? 10'd0 : raster_y + 10'd1;
  assign busy_o     = (state_q != ST_IDLE);

  // Table storage: accepts CPU writes in every state, fields truncated like the detector
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_x[i]     <= '0;
        tbl_y[i]     <= '0;
        tbl_shape[i] <= '0;
        tbl_en[i]    <= 1'b0;
      end
    end else if (tbl_wr) begin
      case (tbl_off[1:0])
        2'd0:    tbl_x[wr_n]     <= register_write_value_i[9:0];
        2'd1:    tbl_y[wr_n]     <= register_write_value_i[9:0];
        2'd2:    tbl_shape[wr_n] <= register_write_value_i[3:0];
        default: tbl_en[wr_n]    <= (register_write_value_i != 16'd0);
      endcase
    end
  end

  // Scheduler FSM: one slot write or one table probe per cycle; bus outputs are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      n_q           <= '0;
      slot_q        <= '0;
      clr_q         <= '0;
      fld_q         <= '0;
      sched_write_o <= 1'b0;
      sched_index_o <= '0;
      sched_value_o <= '0;
    end else begin
      sched_write_o <= 1'b0;
      sched_index_o <= '0;
      sched_value_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            target_q <= next_line;
            n_q      <= '0;
            slot_q   <= '0;
            clr_q    <= '0;
            fld_q    <= '0;
            state_q  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          sched_write_o <= 1'b1;
          sched_index_o <= SLOT_BASE + 12'(clr_q) * 12'd4 + 12'd3;
          sched_value_o <= 16'd0;
          if (clr_q == CW'(NUM_SLOTS - 1)) state_q <= ST_SCAN;
          else                             clr_q   <= clr_q + CW'(1);
        end
        ST_SCAN: begin
          // A hit with all slots used is dropped here (and flagged when enabled)
          if (cur_hit && !slots_full) begin
            fld_q   <= 2'd0;
            state_q <= ST_LOAD;
          end else if (last_n) begin
            state_q <= ST_IDLE;
          end else begin
            n_q <= n_q + IW'(1);
          end
        end
        default: begin
          sched_write_o <= 1'b1;
          sched_index_o <= SLOT_BASE + 12'(slot_q) * 12'd4 + 12'(fld_q);
          case (fld_q)
            2'd0:    sched_value_o <= {6'd0, tbl_x[n_q]};
            2'd1:    sched_value_o <= {6'd0, tbl_y[n_q]};
            2'd2:    sched_value_o <= {12'd0, tbl_shape[n_q]};
            default: sched_value_o <= 16'd1;
          endcase
          if (fld_q == 2'd3) begin
            slot_q <= slot_q + SW'(1);
            if (last_n) begin
              state_q <= ST_IDLE;
            end else begin
              n_q     <= n_q + IW'(1);
              state_q <= ST_SCAN;
            end
          end else begin
            fld_q <= fld_q + 2'd1;
          end
        end
      endcase
    end
  end

`ifdef SPRITE_SCHED_OVERFLOW_EN
  logic ovf_set;
  logic ctrl_wr;
  logic ovf_q;

  assign ovf_set    = (state_q == ST_SCAN) && cur_hit && slots_full;
  assign ctrl_wr    = register_write_i &&
                      (register_index_i == TABLE_BASE + 12'(4 * NUM_SPRITES));
  assign overflow_o = ovf_q;

  // Sticky overflow flag: a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)        ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (ctrl_wr) ovf_q <= 1'b0;
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule
